mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates a single-port synchronous memory between the RV32I core's instruction-fetch requester and its load/store requester, so one unified memory can replace separate instruction and data memories. Sits between the core's fetch/LSU interfaces and the memory macro. Sequences each access with a three-state FSM: issue, wait-for-ready, respond. Data accesses have priority; a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, byte-address width for both requesters and the memory port
- FETCH_STARVE_MAX, 4, consecutive data grants allowed while fetch is pending before fetch is forced to win (range 1..15)

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high with stable if_addr until if_done
- if_addr  in  ADDR_W  fetch byte address
- if_done  out  1  one-cycle pulse; fetch complete, if_rdata valid
- if_rdata  out  32  fetched word, registered
- d_req  in  1  data request; held high with stable payload until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data
- d_be  in  4  store byte enables (ignored for loads)
- d_done  out  1  one-cycle pulse; data access complete, d_rdata valid for loads
- d_rdata  out  32  load word, registered
- mem_en  out  1  memory access active; held until mem_ready sampled high
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  ADDR_W  byte address to memory
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables
- mem_ready  in  1  memory completes the access this cycle; mem_rdata valid this cycle
- mem_rdata  in  32  read data
- dbg_owner  out  2  0 none, 1 fetch, 2 data: current access owner
- dbg_stall  out  1  combinational: (if_req & ~if_done) | (d_req & ~d_done)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if no request, stay. Otherwise select a winner, register the mem_* fields from that requester, set mem_en, set dbg_owner, and go to ACCESS.
- Winner selection:
  - Only one request pending: that requester wins.
  - Both pending: data wins, unless starve_cnt == FETCH_STARVE_MAX, in which case fetch wins.
- starve_cnt (4 bits):
  - Increments on a data grant while if_req is high.
  - Clears on any fetch grant.
  - Saturates at FETCH_STARVE_MAX.
- Fetch grant drives mem_we=0, mem_be=4'hF, mem_addr=if_addr.
- Data grant passes d_we, d_be, d_addr and d_wdata through; mem_be is forced to 4'hF when d_we=0.
- ACCESS: mem_* outputs are held stable. When mem_ready=1:
  - capture mem_rdata into the owner's rdata register (loads and fetches only; a store leaves d_rdata unchanged);
  - clear mem_en;
  - go to RESP.
- RESP: pulse the owner's done for exactly one cycle, clear dbg_owner, go to IDLE.
- Requester rule: after sampling done, a requester drops req or presents a new transaction at the next edge. The request seen in IDLE is always a new transaction.
- Requests are never reordered or merged. Fetch and data are never in flight together.
- Stable payload is a requester obligation. The arbiter does not check it and uses only values sampled in IDLE.

## Timing
- Reset (rst high at a rising edge) gives:
  - state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0;
  - if_done=0, d_done=0, if_rdata=0, d_rdata=0;
  - dbg_owner=0, starve_cnt=0.
- Reset mid-ACCESS abandons the transaction: no done pulse, and mem_en drops at that edge.
- Latency from the request sampled in IDLE at edge N:
  - mem_en is high from edge N.
  - With zero-wait memory (mem_ready=1 in the first ACCESS cycle), done is high in the cycle after edge N+2. Minimum 3 cycles per access.
  - Each wait cycle (mem_ready=0 in ACCESS) adds one cycle.
- Throughput is one access per 3 cycles at best. The IDLE bubble is intentional.
- mem_ready is ignored outside ACCESS.
- Simultaneous fresh requests in IDLE follow the winner-selection rule. The loser stays pending and is re-arbitrated in the next IDLE.

## Test plan
- Reset: hold rst 2 cycles with both reqs high. Required: all outputs 0, no mem_en; first grant comes in the first IDLE after rst falls.
- Single fetch, zero-wait memory: if_addr=0x0000_0010, mem_rdata=0x0051_0093. Required: mem_en high 1 cycle with mem_addr=0x10, mem_be=4'hF, mem_we=0; if_done pulses 3 cycles after the request, with if_rdata=0x0051_0093.
- Store with 2 wait states: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011. Required: mem_* held stable for 3 cycles; d_done 5 cycles after the request; d_rdata unchanged.
- Contention with FETCH_STARVE_MAX=4: if_req and d_req held high continuously. Required: grant order D,D,D,D,F,D,D,D,D,F… with dbg_owner matching.
- Load 0x200 then fetch 0x204 back-to-back, each with a distinct mem_rdata. Required: d_rdata and if_rdata each hold their own word; no cross-contamination; no done pulse on the wrong port.
- rst asserted during ACCESS of a load. Required: mem_en=0 and no d_done afterward; the re-issued request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data wins contention; a starvation counter forces a fetch grant after FETCH_STARVE_MAX data wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned FETCH_STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_owner,
  output logic              dbg_stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_DATA  = 2'd2;
  localparam logic [3:0] STARVE_MAX = 4'(FETCH_STARVE_MAX);

  state_e              state_q, state_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic                if_done_q, if_done_d;
  logic                d_done_q, d_done_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic [1:0]          owner_q, owner_d;
  logic [3:0]          starve_q, starve_d;
  logic                fetch_wins;

  always_comb begin
    state_d     = state_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    fetch_wins  = if_req && (!d_req || (starve_q == STARVE_MAX));

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d  = ACCESS;
          mem_en_d = 1'b1;
          if (fetch_wins) begin
            owner_d    = OWN_FETCH;
            mem_we_d   = 1'b0;
            mem_be_d   = '1;
            mem_addr_d = if_addr;
            starve_d   = '0;
          end else begin
            owner_d     = OWN_DATA;
            mem_we_d    = d_we;
            mem_be_d    = d_we ? d_be : 4'hF;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // Only data wins that keep a waiting fetch out count toward starvation.
            if (if_req && (starve_q != STARVE_MAX)) begin
              starve_d = starve_q + 4'd1;
            end
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          mem_en_d = 1'b0;
          state_d  = RESP;
          if (owner_q == OWN_FETCH) begin
            if_rdata_d = mem_rdata;
          end else if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      RESP: begin
        if_done_d = (owner_q == OWN_FETCH);
        d_done_d  = (owner_q == OWN_DATA);
        owner_d   = OWN_NONE;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign dbg_owner = owner_q;
  assign dbg_stall = (if_req & ~if_done_q) | (d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_done;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [1:0]        dbg_owner;
  logic              dbg_stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W          (ADDR_W),
    .FETCH_STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .dbg_owner(dbg_owner),
    .dbg_stall(dbg_stall)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one transaction in flight at most, tracked by what it is
  // waiting for (memory answer, then the done pulse one edge later).
  typedef struct {
    logic [1:0]  owner;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        cur;
  bit          in_flight;
  bit          answer_due;
  bit          was_reset;
  int unsigned starved;
  logic [31:0] e_if_rdata, e_d_rdata;
  logic        e_if_done, e_d_done;
  logic        prev_mem_en;
  bit          rec_grants;
  logic [1:0]  grants[$];

  task automatic model_edge();
    e_if_done = 1'b0;
    e_d_done  = 1'b0;
    was_reset = 1'b0;
    if (rst) begin
      in_flight  = 1'b0;
      answer_due = 1'b0;
      was_reset  = 1'b1;
      starved    = 0;
      e_if_rdata = '0;
      e_d_rdata  = '0;
      cur.owner  = 2'd0;
      cur.we     = 1'b0;
      cur.be     = 4'h0;
      cur.addr   = '0;
      cur.wdata  = '0;
    end else if (answer_due) begin
      if (cur.owner == 2'd1) e_if_done = 1'b1;
      else                   e_d_done  = 1'b1;
      cur.owner  = 2'd0;
      answer_due = 1'b0;
    end else if (in_flight) begin
      if (mem_ready) begin
        if (cur.owner == 2'd1) e_if_rdata = mem_rdata;
        else if (!cur.we)      e_d_rdata  = mem_rdata;
        in_flight  = 1'b0;
        answer_due = 1'b1;
      end
    end else if (if_req || d_req) begin
      if (if_req && (!d_req || starved >= STARVE_MAX)) begin
        cur.owner = 2'd1;
        cur.we    = 1'b0;
        cur.be    = 4'hF;
        cur.addr  = if_addr;
        starved   = 0;
      end else begin
        cur.owner = 2'd2;
        cur.we    = d_we;
        cur.be    = d_we ? d_be : 4'hF;
        cur.addr  = d_addr;
        cur.wdata = d_wdata;
        if (if_req) starved = (starved + 1 > STARVE_MAX) ? STARVE_MAX : starved + 1;
      end
      in_flight = 1'b1;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check("mem_en",    mem_en,    in_flight);
    check("if_done",   if_done,   e_if_done);
    check("d_done",    d_done,    e_d_done);
    check("dbg_owner", dbg_owner, cur.owner);
    check("if_rdata",  if_rdata,  e_if_rdata);
    check("d_rdata",   d_rdata,   e_d_rdata);
    check("dbg_stall", dbg_stall, (if_req & ~e_if_done) | (d_req & ~e_d_done));
    if (in_flight || was_reset) begin
      check("mem_addr", mem_addr, cur.addr);
      check("mem_we",   mem_we,   cur.we);
      check("mem_be",   mem_be,   cur.be);
      if (cur.owner == 2'd2 || was_reset) check("mem_wdata", mem_wdata, cur.wdata);
    end
    if (rec_grants && mem_en && !prev_mem_en) grants.push_back(dbg_owner);
    prev_mem_en = mem_en;
  endtask

  // Requesters present a fresh transaction (or drop) only after their done.
  task automatic drive(input int unsigned p_if, input int unsigned p_d,
                       input int unsigned p_ready, input int unsigned p_rst_pm);
    if (!if_req || e_if_done) begin
      if ($urandom_range(99) < p_if) begin
        if_req  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end else begin
        if_req = 1'b0;
      end
    end
    if (!d_req || e_d_done) begin
      if ($urandom_range(99) < p_d) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(1));
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = 4'($urandom_range(15));
      end else begin
        d_req = 1'b0;
      end
    end
    mem_ready = ($urandom_range(99) < p_ready);
    mem_rdata = $urandom;
    rst       = ($urandom_range(999) < p_rst_pm);
  endtask

  initial begin
    rst         = 1'b1;
    if_req      = 1'b1;
    if_addr     = 32'h0000_0010;
    d_req       = 1'b1;
    d_we        = 1'b1;
    d_addr      = 32'h0000_0100;
    d_wdata     = 32'hDEAD_BEEF;
    d_be        = 4'b0011;
    mem_ready   = 1'b1;
    mem_rdata   = 32'h0051_0093;
    prev_mem_en = 1'b0;
    rec_grants  = 1'b0;
    starved     = 0;

    cycle();
    cycle();
    rst        = 1'b0;
    rec_grants = 1'b1;

    for (int i = 0; i < 60; i++) begin
      cycle();
      drive(100, 100, 100, 0);
    end
    rec_grants = 1'b0;
    check("grant_count", 32'(grants.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < grants.size(); i++) begin
      check($sformatf("grant_order[%0d]", i), grants[i], (i % 5 == 4) ? 2'd1 : 2'd2);
    end

    for (int i = 0; i < 3000; i++) begin
      cycle();
      drive(60, 60, 60, 5);
    end
    rst = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      cycle();
      drive(20, 30, 40, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
